rom_loader: RTL and testbench
=============================

# rom_loader

Consumes the byte stream from the BL616 UART I/O system (`rom_loading`, `rom_do`, `rom_do_valid`) and writes it into external memory as 16-bit words through a request/acknowledge port.
- Captures the first header bytes into a register bank for mapper/header decode.
- Counts the image size.
- Holds the console core in reset while a load is in progress.
- Sits between the I/O system and the SDRAM arbiter. A small word FIFO absorbs memory-side stalls such as refresh and arbitration.

## Interface
Parameters:
- `ADDR_WIDTH`, 22: word-address width of `mem_addr`.
- `BASE_ADDR`, 0: word address where byte 0 of the image is stored.
- `HDR_BYTES`, 16: number of leading image bytes captured into `header`.
- `FIFO_DEPTH`, 4: word FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1: main logic clock.
- `resetn`  in  1: synchronous, active-low reset.
- `rom_loading`  in  8: load state from the I/O system. 0 = idle, nonzero = loading (the value is the image type).
- `rom_do`  in  8: image data byte.
- `rom_do_valid`  in  1: one-cycle strobe qualifying `rom_do`.
- `mem_addr`  out  ADDR_WIDTH: word address of the current write.
- `mem_din`  out  16: write data. Even byte in [7:0], odd byte in [15:8].
- `mem_be`  out  2: byte enables. [0] = low byte, [1] = high byte.
- `mem_req`  out  1: write request, held at level.
- `mem_ack`  in  1: one-cycle completion pulse from the arbiter.
- `header`  out  8*HDR_BYTES: captured header. Byte k is at [8k+7:8k].
- `rom_type`  out  8: value of `rom_loading` latched at load start.
- `rom_size`  out  24: bytes accepted in the current/last load.
- `core_reset`  out  1: high while loading or flushing.
- `load_done`  out  1: one-cycle pulse when the image is fully written.
- `overflow`  out  1: sticky flag for a dropped word or an address out of range.

## Operation
- Reset values: all outputs 0; state IDLE; FIFO empty; `ld_prev` = 0.
- `ld_prev` is a registered copy of `(rom_loading != 0)`.
  - Start event: `rom_loading != 0` while `ld_prev` = 0.
  - End event: `rom_loading == 0` while `ld_prev` = 1.
- **IDLE:**
  - `rom_do_valid` is ignored.
  - On a start event:
    - Clear `header`, `rom_size`, `overflow`, the byte counter, the pending-byte register and the FIFO.
    - Latch `rom_type`.
    - Set `core_reset` = 1.
    - Go to LOAD.
- **LOAD, on each `rom_do_valid`:**
  - Let n = byte counter.
  - If n < HDR_BYTES, write `header` byte n.
  - Even n: store the byte in the pending register.
  - Odd n: push word {`rom_do`, pending}, be = 2'b11, addr = BASE_ADDR + (n >> 1).
  - The byte counter increments in all cases.
  - `rom_size` = n+1, saturating at 24'hFFFFFF.
- **LOAD, end event:**
  - If n is odd, push the final word {8'h00, pending}, be = 2'b01.
  - Go to FLUSH.
- **FLUSH:**
  - Bytes are ignored.
  - When the FIFO is empty and `mem_req` = 0, go to DONE.
- **DONE (one cycle):**
  - `load_done` = 1, `core_reset` = 0.
  - Return to IDLE.
- **Start event while in LOAD or FLUSH** (loader restarted): the in-flight `mem_req` completes normally; everything else is reinitialised as on a fresh start. No `load_done` is issued.
- **Push with FIFO full:** the word is dropped and `overflow` = 1.
- **Address out of range:** a word with (n >> 1) ≥ 2^ADDR_WIDTH − BASE_ADDR is dropped and `overflow` = 1.
- **Byte count:** internal byte counter is ADDR_WIDTH+1 bits and wraps. `rom_size` saturates.
- **Memory port:**
  - When `mem_req` = 0 and the FIFO is not empty, pop the head into `mem_addr`/`mem_din`/`mem_be` and set `mem_req` = 1.
  - Hold `mem_req`, `mem_addr`, `mem_din` and `mem_be` stable until the cycle `mem_ack` = 1.
  - `mem_req` falls the next cycle.
  - A new request is issued no earlier than one cycle after `mem_req` falls.
- **Spurious `mem_ack`:** `mem_ack` while `mem_req` = 0 is ignored.

## Timing
- **Write latency:** odd byte strobe at cycle t → FIFO entry at t+1 → `mem_req` = 1 at t+2, provided the FIFO was empty and the port idle.
- **Back-to-back requests:** with `mem_ack` at t, `mem_req` = 0 at t+1 and next `mem_req` = 1 at t+2.
- **Header:** visible the cycle after the strobe.
- **`rom_size`:** updates the cycle after each strobe.
- **`core_reset`:** rises the cycle after the start event and falls together with `load_done`.
- **End to done (empty FIFO, no odd tail):**
  - End event seen at t: FLUSH at t+1, DONE at t+2.
  - `load_done` is high during t+2.
  - `core_reset` = 0 from t+3.
- **Coincident events:** a strobe in the same cycle as the end event is still accepted, because state is LOAD that cycle.
- **Throughput:** the arbiter sustains one word per 3 cycles minimum. Upstream delivers at most one byte per ~10 µs.

## Test plan
- **Even-length image:** start with `rom_loading` = 1, send 4 bytes 11 22 33 44, `mem_ack` 1 cycle after each req, then end.
  - Writes (BASE+0, 2211, 11) and (BASE+1, 4433, 11).
  - `rom_size` = 4, `header[31:0]` = 44332211.
  - One `load_done` pulse; `core_reset` low after it.
- **Odd length:** send 3 bytes AA BB CC, then end.
  - Last write is (BASE+1, 00CC, be 01).
  - `load_done` fires only after its ack.
- **Stalled arbiter:** `mem_ack` held low for 200 cycles while 12 bytes arrive one per 2 cycles.
  - The first FIFO_DEPTH+1 words are held (1 in flight, 4 queued); the 6th word is dropped and `overflow` = 1.
  - Retained writes arrive in address order after the stall.
- **Reset mid-load:** assert `resetn` = 0 during a pending `mem_req`.
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent load starts at BASE_ADDR.
- **Restart:** a start event during FLUSH with 2 queued words.
  - The in-flight word completes; queued words are discarded; no `load_done`.
  - New `rom_type` is latched; `rom_size` = 0.
- **Zero-length load:** start then end with no bytes.
  - No `mem_req`; `load_done` 2 cycles after the end event; `rom_size` = 0.

Source files
------------

// File: rtl/rom_loader.sv
// Packs loader bytes into 16-bit memory writes behind a small word FIFO, captures header/size,
// and holds the core in reset until the last word of the image has been acknowledged.
module rl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q;
  logic [PW:0]  rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dat_o   = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn || clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_q <= wr_q + PTR_ONE;
      if (pop_i  && !empty_o) rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[PW-1:0]] <= dat_i;
  end
endmodule

module rom_loader #(
  parameter int ADDR_WIDTH = 22,
  parameter int BASE_ADDR  = 0,
  parameter int HDR_BYTES  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [7:0]              rom_loading,
  input  logic [7:0]              rom_do,
  input  logic                    rom_do_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [15:0]             mem_din,
  output logic [1:0]              mem_be,
  output logic                    mem_req,
  input  logic                    mem_ack,
  output logic [8*HDR_BYTES-1:0]  header,
  output logic [7:0]              rom_type,
  output logic [23:0]             rom_size,
  output logic                    core_reset,
  output logic                    load_done,
  output logic                    overflow
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] BASE_EXT = CW'(BASE_ADDR);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           din;
    logic [1:0]            be;
  } wr_t;

  state_t                 state_q, state_d;
  logic                   ld_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             pend_q, pend_d;
  logic [8*HDR_BYTES-1:0] hdr_q, hdr_d;
  logic [7:0]             type_q, type_d;
  logic [23:0]            size_q, size_d;
  logic                   core_rst_q, core_rst_d;
  logic                   ovf_q, ovf_d;
  logic                   req_q, req_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [15:0]            din_q, din_d;
  logic [1:0]             be_q, be_d;

  logic                   loading, start_ev, end_ev;
  logic                   push_vld, push_ok, pop, fifo_clr;
  logic                   fifo_empty, fifo_full;
  logic [ADDR_WIDTH-1:0]  widx;
  logic [CW-1:0]          wsum;
  wr_t                    push_ent, head;

  assign loading  = (rom_loading != 8'd0);
  assign start_ev = loading && !ld_prev_q;
  assign end_ev   = !loading && ld_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    hdr_d      = hdr_q;
    type_d     = type_q;
    size_d     = size_q;
    core_rst_d = core_rst_q;
    ovf_d      = ovf_q;
    fifo_clr   = 1'b0;
    push_vld   = 1'b0;
    widx       = '0;
    push_ent   = '0;

    case (state_q)
      S_LOAD: begin
        if (rom_do_valid) begin
          for (int k = 0; k < HDR_BYTES; k++) begin
            if (cnt_q == CW'(k)) hdr_d[8*k +: 8] = rom_do;
          end
          if (!cnt_q[0]) begin
            pend_d = rom_do;
          end else begin
            push_vld     = 1'b1;
            widx         = cnt_q[CW-1:1];
            push_ent.din = {rom_do, pend_q};
            push_ent.be  = 2'b11;
          end
          cnt_d  = cnt_q + CNT_ONE;
          size_d = (size_q == 24'hFFFFFF) ? size_q : size_q + 24'd1;
        end
        // Uses the post-strobe count so a byte arriving with the end event is not lost.
        if (end_ev) begin
          if (cnt_d[0]) begin
            push_vld     = 1'b1;
            widx         = cnt_d[CW-1:1];
            push_ent.din = {8'h00, pend_d};
            push_ent.be  = 2'b01;
          end
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fifo_empty && !req_q) state_d = S_DONE;
      end
      S_DONE: begin
        core_rst_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: ;
    endcase

    wsum          = {1'b0, widx} + BASE_EXT;
    push_ent.addr = wsum[ADDR_WIDTH-1:0];

    if (start_ev) begin
      state_d    = S_LOAD;
      cnt_d      = '0;
      pend_d     = '0;
      hdr_d      = '0;
      type_d     = rom_loading;
      size_d     = '0;
      core_rst_d = 1'b1;
      ovf_d      = 1'b0;
      fifo_clr   = 1'b1;
      push_vld   = 1'b0;
    end

    push_ok = push_vld && !wsum[ADDR_WIDTH] && !fifo_full;
    if (push_vld && !push_ok) ovf_d = 1'b1;
  end

  // The in-flight request always completes; a restart only blocks launching stale queued words.
  always_comb begin
    pop    = 1'b0;
    req_d  = req_q;
    addr_d = addr_q;
    din_d  = din_q;
    be_d   = be_q;
    if (req_q) begin
      if (mem_ack) req_d = 1'b0;
    end else if (!fifo_empty && !fifo_clr) begin
      pop    = 1'b1;
      req_d  = 1'b1;
      addr_d = head.addr;
      din_d  = head.din;
      be_d   = head.be;
    end
  end

  rl_fifo #(
    .W     ($bits(wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (fifo_clr),
    .push_i  (push_ok),
    .dat_i   (push_ent),
    .pop_i   (pop),
    .dat_o   (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ld_prev_q  <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= '0;
      hdr_q      <= '0;
      type_q     <= '0;
      size_q     <= '0;
      core_rst_q <= 1'b0;
      ovf_q      <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      ld_prev_q  <= loading;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      hdr_q      <= hdr_d;
      type_q     <= type_d;
      size_q     <= size_d;
      core_rst_q <= core_rst_d;
      ovf_q      <= ovf_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      be_q       <= be_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_be     = be_q;
  assign mem_req    = req_q;
  assign header     = hdr_q;
  assign rom_type   = type_q;
  assign rom_size   = size_q;
  assign core_reset = core_rst_q;
  assign load_done  = (state_q == S_DONE);
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a scoreboard of expected memory writes is checked by an
// arbiter model that acknowledges requests, alongside header/size/reset/done checks.
module tb_rom_loader;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rom_loading = 8'h00;
  logic [7:0]    rom_do = 8'h00;
  logic          rom_do_valid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_be;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic [127:0]  header;
  logic [7:0]    rom_type;
  logic [23:0]   rom_size;
  logic          core_reset;
  logic          load_done;
  logic          overflow;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [1:0]    be;
  } wr_t;

  wr_t expq[$];
  wr_t got_w, exp_w;
  int  checks = 0;
  int  failures = 0;
  int  ack_dly = 0;
  bit  stall = 1'b0;
  int  wait_cnt = 0;
  int  done_cnt = 0;
  int  req_cnt = 0;
  bit  req_prev = 1'b0;
  int  d0, r0;

  always #5 clk = ~clk;

  rom_loader #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (0),
    .HDR_BYTES  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_be       (mem_be),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .header       (header),
    .rom_type     (rom_type),
    .rom_size     (rom_size),
    .core_reset   (core_reset),
    .load_done    (load_done),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rom_do       = b;
    rom_do_valid = 1'b1;
    tick(1);
    rom_do_valid = 1'b0;
    tick(gap);
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_t w;
    w.addr = a;
    w.din  = d;
    w.be   = be;
    expq.push_back(w);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && !(expq.size() == 0 && !mem_req); i++) tick(1);
    chk(tag, (expq.size() == 0 && !mem_req), 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && !load_done; i++) tick(1);
    chk(tag, load_done, 1);
  endtask

  // Arbiter model: acknowledges each request after ack_dly cycles and checks it against the scoreboard.
  always begin
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (load_done) done_cnt++;
    if (mem_req && !req_prev) req_cnt++;
    req_prev = mem_req;
    if (!mem_req) begin
      wait_cnt = 0;
    end else if (!stall) begin
      if (wait_cnt >= ack_dly) begin
        got_w = {mem_addr, mem_din, mem_be};
        chk("sb_write_expected", (expq.size() > 0), 1);
        if (expq.size() > 0) begin
          exp_w = expq.pop_front();
          chk("mem_write", got_w, exp_w);
        end
        mem_ack  = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  initial begin
    logic [7:0] b;

    tick(3);
    chk("rst_outputs", {mem_req, mem_addr, mem_din, mem_be, rom_type, rom_size,
                        core_reset, load_done, overflow}, 0);
    chk("rst_header", header, 0);
    resetn = 1'b1;
    tick(2);

    // Even-length image
    rom_loading = 8'h01;
    tick(1);
    chk("t1_core_reset_rise", core_reset, 1);
    chk("t1_rom_type", rom_type, 8'h01);
    push_exp(0, 16'h2211, 2'b11);
    push_exp(1, 16'h4433, 2'b11);
    send(8'h11, 0);
    chk("t1_hdr0", header[7:0], 8'h11);
    chk("t1_size1", rom_size, 1);
    send(8'h22, 0);
    chk("t1_lat_fifo_stage", mem_req, 0);
    tick(1);
    chk("t1_lat_req", mem_req, 1);
    chk("t1_lat_din", mem_din, 16'h2211);
    tick(3);
    send(8'h33, 3);
    send(8'h44, 3);
    wait_idle("t1_idle");
    chk("t1_size", rom_size, 4);
    chk("t1_header", header[31:0], 32'h44332211);
    d0 = done_cnt;
    rom_loading = 8'h00;
    tick(1);
    chk("t1_done_t1", load_done, 0);
    tick(1);
    chk("t1_done_t2", load_done, 1);
    tick(1);
    chk("t1_done_t3", load_done, 0);
    chk("t1_core_reset_fall", core_reset, 0);
    chk("t1_done_once", done_cnt - d0, 1);
    tick(2);

    // Odd-length image with a slow arbiter
    ack_dly = 6;
    rom_loading = 8'h02;
    tick(1);
    push_exp(0, 16'hBBAA, 2'b11);
    push_exp(1, 16'h00CC, 2'b01);
    send(8'hAA, 1);
    send(8'hBB, 1);
    send(8'hCC, 1);
    rom_loading = 8'h00;
    wait_done("t2_done");
    chk("t2_acked_before_done", expq.size(), 0);
    chk("t2_size", rom_size, 3);
    chk("t2_header", header[23:0], 24'hCCBBAA);
    chk("t2_rom_type", rom_type, 8'h02);
    ack_dly = 0;
    tick(2);

    // Stalled arbiter: one word in flight, FIFO_DEPTH queued, sixth word dropped
    stall = 1'b1;
    rom_loading = 8'h03;
    tick(1);
    for (int w = 0; w < 5; w++) begin
      push_exp(AW'(w), {8'h21 + 8'(2*w), 8'h20 + 8'(2*w)}, 2'b11);
    end
    for (int k = 0; k < 12; k++) begin
      b = 8'h20 + 8'(k);
      send(b, 1);
      if (k == 9) chk("t3_no_ovf_at_5_words", overflow, 0);
    end
    chk("t3_ovf", overflow, 1);
    chk("t3_req_held", mem_req, 1);
    chk("t3_inflight_din", mem_din, 16'h2120);
    tick(176);
    chk("t3_still_held", mem_addr, 0);
    stall = 1'b0;
    wait_idle("t3_drain");
    chk("t3_ovf_sticky", overflow, 1);
    rom_loading = 8'h00;
    wait_done("t3_done");
    chk("t3_size", rom_size, 12);
    tick(2);

    // Reset during a pending request
    stall = 1'b1;
    rom_loading = 8'h04;
    tick(1);
    send(8'h01, 1);
    send(8'h02, 1);
    tick(2);
    chk("t4_req_pending", mem_req, 1);
    resetn = 1'b0;
    rom_loading = 8'h00;
    tick(1);
    chk("t4_rst_outputs", {mem_req, mem_addr, mem_din, mem_be, rom_type, rom_size,
                           core_reset, load_done, overflow}, 0);
    chk("t4_rst_header", header, 0);
    expq.delete();
    stall = 1'b0;
    resetn = 1'b1;
    tick(2);
    rom_loading = 8'h05;
    tick(1);
    push_exp(0, 16'hA55A, 2'b11);
    send(8'h5A, 1);
    send(8'hA5, 1);
    wait_idle("t4_reload_idle");
    chk("t4_rom_type", rom_type, 8'h05);
    rom_loading = 8'h00;
    wait_done("t4_done");
    tick(2);

    // Restart during FLUSH with queued words, then a zero-length load
    stall = 1'b1;
    rom_loading = 8'h06;
    tick(1);
    push_exp(0, 16'h3130, 2'b11);
    for (int k = 0; k < 6; k++) begin
      b = 8'h30 + 8'(k);
      send(b, 1);
    end
    rom_loading = 8'h00;
    tick(2);
    chk("t5_in_flush", core_reset, 1);
    d0 = done_cnt;
    r0 = req_cnt;
    rom_loading = 8'h07;
    tick(1);
    chk("t5_rom_type", rom_type, 8'h07);
    chk("t5_size_clr", rom_size, 0);
    chk("t5_header_clr", header, 0);
    chk("t5_inflight_kept", mem_req, 1);
    stall = 1'b0;
    tick(20);
    chk("t5_inflight_acked", expq.size(), 0);
    chk("t5_no_queued_writes", req_cnt, r0);
    chk("t5_no_done", done_cnt, d0);
    rom_loading = 8'h00;
    tick(1);
    chk("t6_done_t1", load_done, 0);
    tick(1);
    chk("t6_done_t2", load_done, 1);
    chk("t6_size", rom_size, 0);
    tick(1);
    chk("t6_core_reset_fall", core_reset, 0);
    chk("t6_no_req", req_cnt, r0);
    chk("t6_done_once", done_cnt, d0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
